rom_load_arbiter: RTL
=====================

Name: rom_load_arbiter

Overview:
- Owns the single shared port of the game ROM block RAM (program and graphics regions).
- Routes HPS ioctl download writes into the correct region and arbitrates them against game-side reads.
- Sequences the game-core reset around downloads, with a settle interval after each one.
- Latches the mod byte (index 1) and reports whether a complete ROM image was received.

Parameters:
- REGION_AW, 16, address width of one ROM region; region size is 2^REGION_AW bytes.
- SETTLE_CYC, 64, clk_sys cycles the core is held in reset after RESET or download end; must be ≥1.
- DL_AW, 25, ioctl address width.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous active-high reset.
- dl_active  in  1  ioctl_download level.
- dl_wr  in  1  one-cycle write strobe, spaced ≥3 cycles apart.
- dl_index  in  8  ioctl_index.
- dl_addr  in  DL_AW  ioctl_addr.
- dl_data  in  8  ioctl_dout.
- game_req  in  1  read request level, held with game_addr until game_ack.
- game_addr  in  REGION_AW+1  bit[REGION_AW] is region (0 = program, 1 = graphics).
- game_ack  out  1  one-cycle pulse; game_rdata valid this cycle.
- game_rdata  out  8  read data.
- mem_addr  out  REGION_AW+1  shared RAM address.
- mem_we  out  1  shared RAM write enable.
- mem_wdata  out  8  shared RAM write data.
- mem_rdata  in  8  shared RAM read data, 1-cycle latency after address.
- core_reset  out  1  reset to the game core.
- mod_byte  out  8  last byte written with dl_index==1.
- rom_ok  out  1  last completed download covered both regions.

Behaviour:
- Reset: all outputs registered; on RESET they clear to 0, except core_reset=1. State goes to SETTLE, the counter clears, wbuf_v=0 and rd_pend=0. mod_byte also resets to 0.
- FSM states:
  - SETTLE: counter increments each cycle; when it reaches SETTLE_CYC-1, go to RUN.
  - RUN: normal operation.
  - LOAD: entered from any state on dl_active==1, taking priority over a pending SETTLE→RUN. Clears dl_count and rom_ok on entry. When dl_active==0, go to SETTLE with the counter cleared.
- core_reset: 1 in SETTLE and LOAD, 0 in RUN, registered from the state.
- Decode: dl_wr with dl_index==0 and dl_addr < 2^(REGION_AW+1) loads wbuf with {addr[REGION_AW:0], data}, sets wbuf_v=1 on the next edge, and increments dl_count (saturating). Index 0 with out-of-range addresses is ignored. Index 1 latches mod_byte on the next edge; other indices are ignored.
- rom_ok: set on the LOAD→SETTLE transition iff dl_count ≥ 2^(REGION_AW+1).
- Arbitration, evaluated each cycle with fixed priority:
  1. If wbuf_v, issue a write: next edge mem_we=1, mem_addr/mem_wdata from wbuf, wbuf_v=0.
  2. Else if game_req and !rd_pend and !game_ack, issue a read: next edge mem_addr=game_addr, mem_we=0, rd_pend=1.
  3. Else mem_we=0 and mem_addr holds its value.
- Read completion: the cycle after issue, game_ack=1 and game_rdata registered from mem_rdata, rd_pend=0. The requester must drop or change game_req in its ack cycle; no new read is issued in the ack cycle.
- Write latency: dl_wr at cycle T gives wbuf_v at T+1 and mem_we at T+2. Download strobe spacing guarantees wbuf is free before the next strobe.
- A read waiting behind a write is delayed exactly one cycle. Game reads are permitted in any state, since the core is in reset during LOAD.
- Simultaneous events:
  - RESET with dl_wr: RESET wins and the write is dropped.
  - dl_active rising during SETTLE: go to LOAD immediately.
  - RESET mid-read: rd_pend clears and no ack is issued.

Decomposition:
- Shared package rom_load_pkg holds:
  - state enum {ST_SETTLE, ST_RUN, ST_LOAD};
  - IDX_ROM=0 and IDX_MOD=1;
  - region select constants REG_PRG=0 and REG_GFX=1.
- No sub-module; FSM, write buffer and arbiter live in one module.

Test Plan:
- RESET for 2 cycles, then idle → core_reset=1 for exactly SETTLE_CYC cycles after RESET falls, then 0; mod_byte=0x00, rom_ok=0.
- dl_active=1, index 0, write 0x00 to 0x1FFFF as address=data[7:0], then drop dl_active → each write gives mem_we at T+2 with matching addr/data; rom_ok=1 after drop; core_reset 0 SETTLE_CYC cycles later.
- Same download but stopping at 0x0FFFF → rom_ok=0; write to 0x20000 → no mem_we.
- dl_wr index 1 with data 0x01 → mod_byte=0x01 next cycle; no mem_we.
- In RUN, game_req addr 0x10005 held → mem_addr=0x10005 next cycle, game_ack one cycle later with game_rdata=mem_rdata; exactly one ack.
- Write buffered in the same cycle game_req rises → write issued first, read one cycle later, ack at T+3 relative to game_req.

Source files
------------

// File: rtl/rom_load_pkg.sv
// Shared types and constants for the game ROM load/arbitration block.
// Download indices, region selects and the loader FSM states.
package rom_load_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_RUN,
    ST_LOAD
  } state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;

  localparam logic REG_PRG = 1'b0;
  localparam logic REG_GFX = 1'b1;

endpackage

// File: rtl/rom_load_arbiter.sv
// Owns the shared game ROM port: download writes, game reads,
// core reset sequencing, mod byte latch and ROM completeness flag.
module rom_load_arbiter
  import rom_load_pkg::*;
#(
  parameter int REGION_AW  = 16,
  parameter int SETTLE_CYC = 64,
  parameter int DL_AW      = 25
) (
  input  logic                 clk_sys,
  input  logic                 RESET,
  input  logic                 dl_active,
  input  logic                 dl_wr,
  input  logic [7:0]           dl_index,
  input  logic [DL_AW-1:0]     dl_addr,
  input  logic [7:0]           dl_data,
  input  logic                 game_req,
  input  logic [REGION_AW:0]   game_addr,
  output logic                 game_ack,
  output logic [7:0]           game_rdata,
  output logic [REGION_AW:0]   mem_addr,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 core_reset,
  output logic [7:0]           mod_byte,
  output logic                 rom_ok
);

  localparam int MW = REGION_AW + 1;
  localparam int NW = REGION_AW + 2;
  localparam int CW = $clog2(SETTLE_CYC + 1);

  state_t         state;
  state_t         state_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic           rom_ok_n;
  logic           load_entry;
  logic [NW-1:0]  dl_count;

  logic           wbuf_v;
  logic [MW-1:0]  wbuf_addr;
  logic [7:0]     wbuf_data;
  logic           rd_pend;

  logic           in_range;
  logic           rom_wr;
  logic           mod_wr;

  assign in_range = (dl_addr >> MW) == '0;
  assign rom_wr   = dl_wr && (dl_index == IDX_ROM) && in_range;
  assign mod_wr   = dl_wr && (dl_index == IDX_MOD);

  // Next state: a download preempts everything, else settle then run.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rom_ok_n   = rom_ok;
    load_entry = 1'b0;
    if (dl_active && state != ST_LOAD) begin
      state_n    = ST_LOAD;
      load_entry = 1'b1;
      rom_ok_n   = 1'b0;
    end else begin
      unique case (state)
        ST_SETTLE: begin
          if (cnt == CW'(SETTLE_CYC - 1))
            state_n = ST_RUN;
          else
            cnt_n = cnt + CW'(1);
        end
        ST_LOAD: begin
          if (!dl_active) begin
            state_n  = ST_SETTLE;
            cnt_n    = '0;
            rom_ok_n = dl_count[NW-1];
          end
        end
        default: ;
      endcase
    end
  end

  // State, settle counter, core reset and completeness flag registers.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state      <= ST_SETTLE;
      cnt        <= '0;
      core_reset <= 1'b1;
      rom_ok     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      core_reset <= (state_n != ST_RUN);
      rom_ok     <= rom_ok_n;
    end
  end

  // Download byte count (saturating) and mod byte latch.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      dl_count <= '0;
      mod_byte <= 8'h00;
    end else begin
      if (load_entry)
        dl_count <= rom_wr ? NW'(1) : '0;
      else if (rom_wr && !(&dl_count))
        dl_count <= dl_count + NW'(1);
      if (mod_wr)
        mod_byte <= dl_data;
    end
  end

  // Port arbiter: buffered write first, then a new game read.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      wbuf_v     <= 1'b0;
      wbuf_addr  <= '0;
      wbuf_data  <= 8'h00;
      rd_pend    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      game_ack   <= 1'b0;
      game_rdata <= 8'h00;
    end else begin
      mem_we <= 1'b0;
      if (wbuf_v) begin
        mem_we    <= 1'b1;
        mem_addr  <= wbuf_addr;
        mem_wdata <= wbuf_data;
        wbuf_v    <= 1'b0;
      end else if (game_req && !rd_pend && !game_ack) begin
        mem_addr <= game_addr;
        rd_pend  <= 1'b1;
      end
      if (rd_pend) begin
        rd_pend    <= 1'b0;
        game_ack   <= 1'b1;
        game_rdata <= mem_rdata;
      end else begin
        game_ack <= 1'b0;
      end
      if (rom_wr) begin
        wbuf_v    <= 1'b1;
        wbuf_addr <= dl_addr[MW-1:0];
        wbuf_data <= dl_data;
      end
    end
  end

endmodule
